micro_pipe_stage: RTL and testbench
===================================

// Module: micro_pipe_stage
// PURPOSE
//   Parametrised elastic pipeline for microinstruction control fields (ALU, SH, C, T).
//   Carries decoded control from the microsequencer to the datapath over DEPTH register stages.
//   Adds what a plain field pass-through lacks: per-stage valid bits, valid/ready backpressure
//   with bubble collapsing, a flush that inserts NOPs, and an occupancy count.
// PARAMETERS
//   ALU_W  4  width of ALU control field
//   SH_W   2  width of shifter control field
//   C_W    6  width of C-bus / destination select field
//   T_W    7  width of timing / next-address field
//   DEPTH  2  number of register stages, >= 1
// PORTS
//   clock      in   1                 system clock; all state updates on rising edge
//   reset      in   1                 synchronous, active-high reset
//   flush      in   1                 discard every in-flight microinstruction
//   in_valid   in   1                 upstream holds a valid microinstruction
//   in_ready   out  1                 stage 0 can accept this cycle
//   ALU_in     in   ALU_W             ALU field in
//   SH_in      in   SH_W              shifter field in
//   C_in       in   C_W               C field in
//   T_in       in   T_W               T field in
//   out_valid  out  1                 last stage holds a valid microinstruction
//   out_ready  in   1                 datapath consumes the output this cycle
//   ALU_out    out  ALU_W             ALU field out
//   SH_out     out  SH_W              shifter field out
//   C_out      out  C_W               C field out
//   T_out      out  T_W               T field out
//   occupancy  out  $clog2(DEPTH+1)   number of valid stages
// BEHAVIOUR
//   - Reset: all stage valid bits 0, all stage fields 0. Outputs after reset:
//     out_valid=0, occupancy=0, *_out=0, in_ready=1 (if flush=0).
//   - Stage k (0..DEPTH-1, stage DEPTH-1 drives the outputs) advances when
//     !v[k] || adv[k+1]. adv[DEPTH] = out_ready. This chain is combinational, so bubbles collapse.
//   - in_ready = adv[0] && !flush.
//   - Input transfer occurs when in_valid && in_ready. On transfer, stage 0 loads the
//     fields and sets v[0]=1. If stage 0 advances without a transfer, v[0] clears.
//   - Output transfer occurs when out_valid && out_ready.
//   - When a stage advances, it loads the fields and valid bit of stage k-1.
//     A stage that does not advance holds its fields and valid bit unchanged.
//   - Fields are loaded only when the incoming valid bit is 1. An emptied stage keeps
//     stale fields, but the outputs mask them (next rule).
//   - *_out = out_valid ? stage fields : 0, so 0 is the NOP encoding.
//     Outputs are registered, with an AND mask only.
//   - Latency: an item accepted at edge N shows out_valid=1 after edge N+DEPTH-1,
//     given no stalls. Throughput is 1 per cycle while out_ready=1.
//   - Full: all DEPTH stages valid and out_ready=0 -> in_ready=0. Every field holds stable.
//   - Full with out_ready=1: input and output transfers both occur in the same cycle.
//     Occupancy is unchanged.
//   - Occupancy next = occupancy + in_xfer - out_xfer. It saturates by construction at 0..DEPTH.
//   - Flush (synchronous):
//       - in_ready=0, so no input transfer occurs.
//       - An output transfer in the flush cycle still completes; the consumer keeps it.
//       - At the next edge all v[k]=0 and occupancy=0. Fields are left as is, masked at the output.
//   - reset overrides flush. Reset mid-stream drops all contents exactly like flush,
//     and also zeroes the fields.
//   - DEPTH=1 is legal: a single skid-free register with in_ready = !v[0] || out_ready.
// TESTING
//   1. Reset then idle -> out_valid=0, *_out=0, occupancy=0, in_ready=1.
//   2. DEPTH=2, out_ready=1, push ALU=4'hA,SH=2'b01,C=6'h15,T=7'h3C at edge 0
//      -> the same fields appear with out_valid=1 after edge 1.
//   3. out_ready=0, stream items 1,2,3 -> occupancy 1,2,2; in_ready=0 once full; item 3 held upstream.
//      Raise out_ready -> items emerge in order 1,2,3 with no loss or duplication.
//   4. Two items in flight, pulse flush with in_valid=1 -> in_ready=0 that cycle.
//      Next cycle out_valid=0, occupancy=0, *_out=0; the input item is not accepted.
//   5. Full, with out_ready=1 and in_valid=1 every cycle for 10 cycles
//      -> one transfer in and one out per cycle; occupancy stays 2.
//   6. Random valid/ready/flush for 10k cycles vs a reference queue model
//      -> order preserved and occupancy matches; DEPTH=1 and DEPTH=4 both pass.

Source files
------------

// File: rtl/micro_pipe_stage.sv
// micro_pipe_stage: elastic DEPTH-stage pipeline for microinstruction
// control fields with valid/ready backpressure, flush and occupancy.
module micro_pipe_stage #(
  parameter int ALU_W = 4,
  parameter int SH_W  = 2,
  parameter int C_W   = 6,
  parameter int T_W   = 7,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_W-1:0]           ALU_in,
  input  logic [SH_W-1:0]            SH_in,
  input  logic [C_W-1:0]             C_in,
  input  logic [T_W-1:0]             T_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ALU_W-1:0]           ALU_out,
  output logic [SH_W-1:0]            SH_out,
  output logic [C_W-1:0]             C_out,
  output logic [T_W-1:0]             T_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int FW = ALU_W + SH_W + C_W + T_W;
  localparam int OW = $clog2(DEPTH+1);

  logic [FW-1:0]    f_q [DEPTH];
  logic [FW-1:0]    f_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [DEPTH-1:0] adv;
  logic             in_xfer, out_xfer, last_v;
  logic [FW-1:0]    in_f, out_f;

  assign in_f = {ALU_in, SH_in, C_in, T_in};

  // Stage k may load when the consumer takes data or any later stage has a hole.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!v_q[j]) adv[k] = 1'b1;
      end
    end
  end

  assign last_v   = v_q[DEPTH-1];
  assign in_ready = adv[0] && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = last_v && out_ready;

  always_comb begin
    v_d = v_q;
    f_d = f_q;
    if (adv[0]) begin
      v_d[0] = in_xfer;
      if (in_xfer) f_d[0] = in_f;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) f_d[k] = f_q[k-1];
      end
    end
    if (flush) v_d = '0;
  end

  always_comb begin
    occ_d = occ_q + OW'(in_xfer) - OW'(out_xfer);
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) f_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int k = 0; k < DEPTH; k++) f_q[k] <= f_d[k];
    end
  end

  // Empty output reads as all-zero NOP.
  assign out_f     = f_q[DEPTH-1] & {FW{last_v}};
  assign out_valid = last_v;
  assign occupancy = occ_q;
  assign {ALU_out, SH_out, C_out, T_out} = out_f;

endmodule

// File: tb/tb_micro_pipe_stage.sv
// tb_micro_pipe_stage: directed and randomized checks of DEPTH=1,2,4
// instances against an item-list reference model.
module tb_micro_pipe_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] alu_i = '0;
  logic [1:0] sh_i = '0;
  logic [5:0] c_i = '0;
  logic [6:0] t_i = '0;

  logic       ov [3];
  logic       ir [3];
  logic [3:0] alu_o [3];
  logic [1:0] sh_o [3];
  logic [5:0] c_o [3];
  logic [6:0] t_o [3];
  logic [0:0] occ_w0;
  logic [1:0] occ_w1;
  logic [2:0] occ_w2;
  logic [2:0] occ_o [3];

  assign occ_o[0] = {2'b00, occ_w0};
  assign occ_o[1] = {1'b0, occ_w1};
  assign occ_o[2] = occ_w2;

  always #5 clk = ~clk;

  micro_pipe_stage #(.DEPTH(1)) u1 (
    .clock(clk), .reset(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]),
    .ALU_in(alu_i), .SH_in(sh_i), .C_in(c_i), .T_in(t_i),
    .out_valid(ov[0]), .out_ready(out_ready),
    .ALU_out(alu_o[0]), .SH_out(sh_o[0]),
    .C_out(c_o[0]), .T_out(t_o[0]),
    .occupancy(occ_w0));

  micro_pipe_stage #(.DEPTH(2)) u2 (
    .clock(clk), .reset(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]),
    .ALU_in(alu_i), .SH_in(sh_i), .C_in(c_i), .T_in(t_i),
    .out_valid(ov[1]), .out_ready(out_ready),
    .ALU_out(alu_o[1]), .SH_out(sh_o[1]),
    .C_out(c_o[1]), .T_out(t_o[1]),
    .occupancy(occ_w1));

  micro_pipe_stage #(.DEPTH(4)) u4 (
    .clock(clk), .reset(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]),
    .ALU_in(alu_i), .SH_in(sh_i), .C_in(c_i), .T_in(t_i),
    .out_valid(ov[2]), .out_ready(out_ready),
    .ALU_out(alu_o[2]), .SH_out(sh_o[2]),
    .C_out(c_o[2]), .T_out(t_o[2]),
    .occupancy(occ_w2));

  int nchk = 0;
  int nerr = 0;
  int dep [3] = '{1, 2, 4};

  // Model: per instance, in-flight items oldest first with stage position.
  int          mcnt [3];
  int          mpos [3][4];
  logic [18:0] mdat [3][4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] obs(input int d);
    return {alu_o[d], sh_o[d], c_o[d], t_o[d]};
  endfunction

  function automatic logic [18:0] mk(input logic [3:0] a, input logic [1:0] s,
                                     input logic [5:0] c, input logic [6:0] t);
    return {a, s, c, t};
  endfunction

  task automatic model_cycle(input int d, input logic r, input logic iv,
                             input logic fl, input logic ordy,
                             input logic [18:0] it);
    int          n, dd, nn;
    bit          mv [4];
    bit          adv0, exp_ov, exp_ir;
    logic [18:0] exp_f;
    int          npos [4];
    logic [18:0] ndat [4];
    string       tg;
    n  = mcnt[d];
    dd = dep[d];
    tg = $sformatf("D%0d", dd);
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) mv[i] = (mpos[d][0] == dd - 1) ? ordy : 1'b1;
      else mv[i] = (mpos[d][i] + 1 != mpos[d][i-1]) || mv[i-1];
    end
    if (n == 0) adv0 = 1'b1;
    else if (mpos[d][n-1] > 0) adv0 = 1'b1;
    else adv0 = mv[n-1];
    exp_ov = (n > 0) && (mpos[d][0] == dd - 1);
    exp_f  = exp_ov ? mdat[d][0] : 19'd0;
    exp_ir = adv0 && !fl;
    check({tg, ".out_valid"}, 32'(ov[d]), 32'(exp_ov));
    check({tg, ".fields"}, 32'(obs(d)), 32'(exp_f));
    check({tg, ".occupancy"}, 32'(occ_o[d]), 32'(n));
    check({tg, ".in_ready"}, 32'(ir[d]), 32'(exp_ir));
    nn = 0;
    if (!r && !fl) begin
      for (int i = 0; i < n; i++) begin
        if (!(mv[i] && mpos[d][i] == dd - 1)) begin
          npos[nn] = mpos[d][i] + (mv[i] ? 1 : 0);
          ndat[nn] = mdat[d][i];
          nn++;
        end
      end
      if (iv && exp_ir) begin
        npos[nn] = 0;
        ndat[nn] = it;
        nn++;
      end
    end
    for (int i = 0; i < nn; i++) begin
      mpos[d][i] = npos[i];
      mdat[d][i] = ndat[i];
    end
    mcnt[d] = nn;
  endtask

  task automatic cyc(input logic r, input logic iv, input logic fl,
                     input logic ordy, input logic [18:0] it);
    @(negedge clk);
    rst = r;
    in_valid = iv;
    flush = fl;
    out_ready = ordy;
    {alu_i, sh_i, c_i, t_i} = it;
    #1;
    for (int d = 0; d < 3; d++) model_cycle(d, r, iv, fl, ordy, it);
  endtask

  initial begin
    logic [18:0] ita, it1, it2, it3;
    logic [18:0] pk [12];
    for (int d = 0; d < 3; d++) mcnt[d] = 0;
    repeat (2) @(posedge clk);

    // Reset then idle
    cyc(0, 0, 0, 0, '0);
    check("rst.out_valid", 32'(ov[1]), 32'd0);
    check("rst.occupancy", 32'(occ_o[1]), 32'd0);
    check("rst.in_ready", 32'(ir[1]), 32'd1);
    check("rst.fields", 32'(obs(1)), 32'd0);

    // Two-edge latency at DEPTH=2
    ita = mk(4'hA, 2'b01, 6'h15, 7'h3C);
    cyc(0, 1, 0, 1, ita);
    cyc(0, 0, 0, 1, '0);
    check("lat.early_valid", 32'(ov[1]), 32'd0);
    cyc(0, 0, 0, 1, '0);
    check("lat.out_valid", 32'(ov[1]), 32'd1);
    check("lat.fields", 32'(obs(1)), 32'(ita));

    // Backpressure fill then drain in order
    it1 = mk(4'h1, 2'b10, 6'h01, 7'h11);
    it2 = mk(4'h2, 2'b11, 6'h02, 7'h22);
    it3 = mk(4'h3, 2'b00, 6'h03, 7'h33);
    cyc(0, 1, 0, 0, it1);
    cyc(0, 1, 0, 0, it2);
    check("bp.occ1", 32'(occ_o[1]), 32'd1);
    cyc(0, 1, 0, 0, it3);
    check("bp.occ2", 32'(occ_o[1]), 32'd2);
    check("bp.full_ready", 32'(ir[1]), 32'd0);
    cyc(0, 1, 0, 1, it3);
    check("bp.out1", 32'(obs(1)), 32'(it1));
    cyc(0, 0, 0, 1, '0);
    check("bp.out2", 32'(obs(1)), 32'(it2));
    cyc(0, 0, 0, 1, '0);
    check("bp.out3", 32'(obs(1)), 32'(it3));
    cyc(0, 0, 0, 1, '0);
    check("bp.empty", 32'(ov[1]), 32'd0);

    // Flush with two in flight
    cyc(0, 1, 0, 0, it1);
    cyc(0, 1, 0, 0, it2);
    cyc(0, 1, 1, 0, it3);
    check("fl.in_ready", 32'(ir[1]), 32'd0);
    cyc(0, 0, 0, 0, '0);
    check("fl.out_valid", 32'(ov[1]), 32'd0);
    check("fl.occupancy", 32'(occ_o[1]), 32'd0);
    check("fl.fields", 32'(obs(1)), 32'd0);

    // Full streaming: one in, one out per cycle
    for (int k = 0; k < 12; k++) pk[k] = mk(4'(k), 2'(k), 6'(k * 5), 7'(k * 9 + 1));
    cyc(0, 1, 0, 1, pk[0]);
    cyc(0, 1, 0, 1, pk[1]);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 1, pk[i+2]);
      check("st.occupancy", 32'(occ_o[1]), 32'd2);
      check("st.in_ready", 32'(ir[1]), 32'd1);
      check("st.fields", 32'(obs(1)), 32'(pk[i]));
    end

    // Randomized run against the model for all three depths
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(1499) == 0, $urandom_range(3) != 0,
          $urandom_range(49) == 0, $urandom_range(2) != 0,
          19'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
